// File: rtl/pc_ctrl_pkg.sv
// Shared PC-control types: sequencer FSM states, interrupt source encoding,
// nesting default and the PC redirect control codes.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRE,
    ST_HOLD
  } seq_state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_NMI,
    SRC_IRQ,
    SRC_TMR
  } irq_src_t;

  localparam int NEST_DEPTH_DEFAULT = 7;

  typedef enum logic [2:0] {
    PC_NOP,
    PC_JUMP,
    PC_BRANCH,
    PC_CALL,
    PC_RETURN,
    PC_FLUSH,
    PC_HALT
  } pc_ctrl_t;

endpackage

// File: rtl/irq_period_timer.sv
// Periodic tick generator: a write loads period and counter; tick is high in
// the cycle the counter reaches 1, giving exactly one tick every period cycles.
module irq_period_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  output logic         tick
);

  logic [W-1:0] period;
  logic [W-1:0] count;

  assign tick = (period != '0) && (count == W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period <= '0;
      count  <= '0;
    end else if (wr) begin
      period <= wdata;
      count  <= wdata;
    end else if (period != '0) begin
      if (count <= W'(1)) count <= period;
      else                count <= count - W'(1);
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer feeding the PC's I0/I1/Timer_Interrupt inputs with one
// pulse at a time. Timer path enabled by defining INTERRUPT_SEQUENCER_TIMER_EN.
module interrupt_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter int TIMER_W    = 16,
  parameter int NEST_DEPTH = NEST_DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               nmi_in,
  input  logic               irq_in,
  input  logic               int_enable,
  input  logic               pc_ready,
  input  logic               isr_return,
  input  logic               timer_wr,
  input  logic [TIMER_W-1:0] timer_wdata,
  output logic               irq_nmi,
  output logic               irq_mask,
  output logic               irq_timer,
  output logic [2:0]         isr_depth,
  output logic               missed_tick,
  output logic               ret_err
);

  seq_state_t state, state_next;
  irq_src_t   sel;
  logic nmi_prev, irq_prev;
  logic p_nmi, p_irq, p_tmr;
  logic rise_nmi, rise_irq;
  logic el_nmi, el_irq, el_tmr;
  logic depth_zero, depth_room, depth_inc;

  assign rise_nmi   = nmi_in & ~nmi_prev;
  assign rise_irq   = irq_in & ~irq_prev;
  assign depth_zero = (isr_depth == 3'd0);
  assign depth_room = (isr_depth < 3'(NEST_DEPTH));
  assign depth_inc  = (state == ST_FIRE);

  // Maskable sources never nest: they need an empty ISR stack.
  assign el_nmi = p_nmi & depth_room;
  assign el_irq = p_irq & int_enable & depth_zero;
  assign el_tmr = p_tmr & int_enable & depth_zero;

  always_comb begin
    state_next = state;
    sel        = SRC_NONE;
    case (state)
      ST_IDLE: begin
        if (pc_ready && (el_nmi || el_irq || el_tmr)) begin
          state_next = ST_FIRE;
          if (el_nmi)      sel = SRC_NMI;
          else if (el_irq) sel = SRC_IRQ;
          else             sel = SRC_TMR;
        end
      end
      ST_FIRE: state_next = ST_HOLD;
      default: state_next = ST_IDLE;
    endcase
  end

  // A fresh edge coinciding with the clear keeps the pending bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      nmi_prev <= 1'b0;
      irq_prev <= 1'b0;
      p_nmi    <= 1'b0;
      p_irq    <= 1'b0;
      irq_nmi  <= 1'b0;
      irq_mask <= 1'b0;
    end else begin
      state    <= state_next;
      nmi_prev <= nmi_in;
      irq_prev <= irq_in;
      p_nmi    <= (p_nmi && (sel != SRC_NMI)) || rise_nmi;
      p_irq    <= (p_irq && (sel != SRC_IRQ)) || rise_irq;
      irq_nmi  <= (sel == SRC_NMI);
      irq_mask <= (sel == SRC_IRQ);
    end
  end

  // A dispatch and a return in the same cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isr_depth <= 3'd0;
      ret_err   <= 1'b0;
    end else if (depth_inc && !isr_return) begin
      isr_depth <= isr_depth + 3'd1;
    end else if (!depth_inc && isr_return) begin
      if (depth_zero) ret_err   <= 1'b1;
      else            isr_depth <= isr_depth - 3'd1;
    end
  end

`ifdef INTERRUPT_SEQUENCER_TIMER_EN
  logic tick;

  irq_period_timer #(.W(TIMER_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .wr    (timer_wr),
    .wdata (timer_wdata),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_tmr       <= 1'b0;
      missed_tick <= 1'b0;
      irq_timer   <= 1'b0;
    end else begin
      p_tmr     <= (p_tmr && (sel != SRC_TMR)) || tick;
      irq_timer <= (sel == SRC_TMR);
      if (tick && p_tmr && (sel != SRC_TMR)) missed_tick <= 1'b1;
    end
  end
`else
  logic unused_timer;
  assign unused_timer = ^{timer_wr, timer_wdata};
  assign p_tmr        = 1'b0;
  assign irq_timer    = 1'b0;
  assign missed_tick  = 1'b0;
`endif

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: expected pulses (source, cycle) are
// queued as stimulus is driven and matched by a pulse monitor.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        nmi_in = 1'b0;
  logic        irq_in = 1'b0;
  logic        int_enable = 1'b0;
  logic        pc_ready = 1'b0;
  logic        isr_return = 1'b0;
  logic        timer_wr = 1'b0;
  logic [15:0] timer_wdata = '0;
  logic        irq_nmi, irq_mask, irq_timer;
  logic [2:0]  isr_depth;
  logic        missed_tick, ret_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [17:0] exp_q[$];
  logic [17:0] got, want;
  logic [1:0]  src;

  interrupt_sequencer #(.TIMER_W(16), .NEST_DEPTH(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .nmi_in      (nmi_in),
    .irq_in      (irq_in),
    .int_enable  (int_enable),
    .pc_ready    (pc_ready),
    .isr_return  (isr_return),
    .timer_wr    (timer_wr),
    .timer_wdata (timer_wdata),
    .irq_nmi     (irq_nmi),
    .irq_mask    (irq_mask),
    .irq_timer   (irq_timer),
    .isr_depth   (isr_depth),
    .missed_tick (missed_tick),
    .ret_err     (ret_err)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pulse(input logic [1:0] s, input int at);
    logic [31:0] at_v;
    at_v = at;
    exp_q.push_back({s, at_v[15:0]});
  endtask

  task automatic ret_pulse();
    isr_return = 1'b1;
    wait_cycles(1);
    isr_return = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_nmi"},    irq_nmi,     1'b0);
    check({tag, "_mask"},   irq_mask,    1'b0);
    check({tag, "_timer"},  irq_timer,   1'b0);
    check({tag, "_depth"},  isr_depth,   3'd0);
    check({tag, "_missed"}, missed_tick, 1'b0);
    check({tag, "_reterr"}, ret_err,     1'b0);
  endtask

  // scoreboard: every observed pulse must match the queue head (source + cycle)
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      assert ($countones({irq_nmi, irq_mask, irq_timer}) <= 1) else begin
        n_err++;
        $error("FAIL onehot: observed %b expected at most one", {irq_nmi, irq_mask, irq_timer});
      end
      if (irq_nmi || irq_mask || irq_timer) begin
        src = irq_nmi ? 2'd1 : (irq_mask ? 2'd2 : 2'd3);
        got = {src, cyc[15:0]};
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_pulse: observed src %0d at cycle %0d expected none", src, cyc);
        end
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          n_cmp++;
          assert (got === want) else begin
            n_err++;
            $error("FAIL pulse: observed src %0d cyc %0d expected src %0d cyc %0d",
                   got[17:16], got[15:0], want[17:16], want[15:0]);
          end
        end
      end
    end
  end

  initial begin
    int c, r, e, w;

    // reset state
    wait_cycles(3);
    check_idle_outputs("reset");
    reset = 1'b0;
    pc_ready = 1'b1;
    wait_cycles(2);

    // single NMI: edge in c, pulse in c+2, depth 1 from c+3
    c = cyc;
    nmi_in = 1'b1;
    expect_pulse(2'd1, c + 2);
    wait_cycles(2);
    check("nmi_depth_before", isr_depth, 3'd0);
    wait_cycles(1);
    check("nmi_depth_after", isr_depth, 3'd1);
    wait_cycles(2);
    nmi_in = 1'b0;
    ret_pulse();
    check("nmi_depth_ret", isr_depth, 3'd0);

    // simultaneous NMI + IRQ: NMI first, IRQ waits for depth 0
    int_enable = 1'b1;
    wait_cycles(1);
    c = cyc;
    nmi_in = 1'b1;
    irq_in = 1'b1;
    expect_pulse(2'd1, c + 2);
    wait_cycles(12);
    nmi_in = 1'b0;
    irq_in = 1'b0;
    check("simul_depth_held", isr_depth, 3'd1);
    r = cyc;
    expect_pulse(2'd2, r + 2);
    ret_pulse();
    check("simul_depth_ret", isr_depth, 3'd0);
    wait_cycles(2);
    check("simul_depth_irq", isr_depth, 3'd1);
    ret_pulse();
    check("simul_depth_end", isr_depth, 3'd0);

    // masking: pending IRQ fires one cycle after int_enable rises
    int_enable = 1'b0;
    wait_cycles(1);
    irq_in = 1'b1;
    wait_cycles(2);
    irq_in = 1'b0;
    wait_cycles(20);
    check("mask_held_depth", isr_depth, 3'd0);
    e = cyc;
    int_enable = 1'b1;
    expect_pulse(2'd2, e + 1);
    wait_cycles(2);
    check("mask_depth", isr_depth, 3'd1);
    ret_pulse();

    // readiness: pc_ready low delays dispatch
    int_enable = 1'b0;
    irq_in = 1'b1;
    wait_cycles(2);
    irq_in = 1'b0;
    wait_cycles(3);
    pc_ready = 1'b0;
    int_enable = 1'b1;
    wait_cycles(5);
    check("ready_held_depth", isr_depth, 3'd0);
    pc_ready = 1'b1;
    expect_pulse(2'd2, cyc + 1);
    wait_cycles(3);
    check("ready_depth", isr_depth, 3'd1);
    ret_pulse();
    check("ready_depth_ret", isr_depth, 3'd0);

    // nesting limit: 8 NMI edges, only 7 dispatched until a return
    int_enable = 1'b0;
    for (int k = 0; k < 8; k++) begin
      c = cyc;
      nmi_in = 1'b1;
      if (k < 7) expect_pulse(2'd1, c + 2);
      wait_cycles(2);
      nmi_in = 1'b0;
      wait_cycles(3);
    end
    check("nest_depth_full", isr_depth, 3'd7);
    wait_cycles(5);
    check("nest_depth_still", isr_depth, 3'd7);
    r = cyc;
    expect_pulse(2'd1, r + 2);
    ret_pulse();
    check("nest_depth_ret", isr_depth, 3'd6);
    wait_cycles(2);
    check("nest_depth_refill", isr_depth, 3'd7);
    isr_return = 1'b1;
    wait_cycles(7);
    isr_return = 1'b0;
    check("nest_depth_drain", isr_depth, 3'd0);
    check("nest_reterr", ret_err, 1'b0);

    // timer: period 4 written in w, first tick pulse at w+6
    int_enable = 1'b1;
    wait_cycles(1);
    w = cyc;
    timer_wr = 1'b1;
    timer_wdata = 16'd4;
`ifdef INTERRUPT_SEQUENCER_TIMER_EN
    expect_pulse(2'd3, w + 6);
`endif
    wait_cycles(1);
    timer_wr = 1'b0;
    wait_cycles(11);
`ifdef INTERRUPT_SEQUENCER_TIMER_EN
    check("tmr_depth", isr_depth, 3'd1);
`else
    check("tmr_depth", isr_depth, 3'd0);
`endif
    check("tmr_missed_before", missed_tick, 1'b0);
    wait_cycles(1);
`ifdef INTERRUPT_SEQUENCER_TIMER_EN
    check("tmr_missed_after", missed_tick, 1'b1);
`else
    check("tmr_missed_after", missed_tick, 1'b0);
`endif
    wait_cycles(1);
    timer_wr = 1'b1;
    timer_wdata = 16'd0;
    wait_cycles(1);
    timer_wr = 1'b0;
    wait_cycles(1);
`ifdef INTERRUPT_SEQUENCER_TIMER_EN
    expect_pulse(2'd3, cyc + 2);
    ret_pulse();
    wait_cycles(3);
    check("tmr_held_depth", isr_depth, 3'd1);
    ret_pulse();
`else
    wait_cycles(4);
    check("tmr_held_depth", isr_depth, 3'd0);
`endif
    check("tmr_depth_end", isr_depth, 3'd0);
    int_enable = 1'b0;

    // spurious return at depth 0
    wait_cycles(2);
    check("spur_reterr_before", ret_err, 1'b0);
    ret_pulse();
    check("spur_reterr_after", ret_err, 1'b1);
    check("spur_depth", isr_depth, 3'd0);

    // reset while the NMI pulse is in flight
    wait_cycles(1);
    c = cyc;
    nmi_in = 1'b1;
    expect_pulse(2'd1, c + 2);
    wait_cycles(2);
    @(negedge clk);
    #1;
    reset = 1'b1;
    nmi_in = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("midreset");
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(10);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
